// File: rtl/vga_sync_gen.sv
// Raster timing generator: free-running h/v counters with registered
// sync, active-video, coordinate and line/frame strobe outputs.
module vga_sync_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk_in,
    input  logic       rst_n,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       line_start,
    output logic       frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;

    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       von_q, von_d;
    logic [9:0] px_q;
    logic [9:0] py_q;
    logic       ls_q, ls_d;
    logic       fs_q, fs_d;

    logic h_wrap;
    logic v_wrap;

    assign h_wrap = (h_q == H_LAST);
    assign v_wrap = (v_q == V_LAST);

    always_comb begin
        h_d = h_q + 10'd1;
        v_d = v_q;
        if (h_wrap) begin
            h_d = '0;
            v_d = v_wrap ? '0 : v_q + 10'd1;
        end
    end

    // Decode the current counter position; registered below so the
    // outputs describe position k-1 at edge k.
    always_comb begin
        hsync_d = ~SYNC_POL;
        vsync_d = ~SYNC_POL;
        if ((h_q >= HS_BEG) && (h_q <= HS_END)) hsync_d = SYNC_POL;
        if ((v_q >= VS_BEG) && (v_q <= VS_END)) vsync_d = SYNC_POL;
        von_d = (h_q < H_ACT) && (v_q < V_ACT);
        ls_d  = (h_q == 10'd0);
        fs_d  = (h_q == 10'd0) && (v_q == 10'd0);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            h_q     <= '0;
            v_q     <= '0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            von_q   <= 1'b0;
            px_q    <= '0;
            py_q    <= '0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            von_q   <= von_d;
            px_q    <= h_q;
            py_q    <= v_q;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = von_q;
    assign pixel_x     = px_q;
    assign pixel_y     = py_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default 640x480 timing on one instance, a tiny
// 8x6 raster on a second instance for full-frame behaviour.
module tb_vga_sync_gen;

    logic       clk;
    logic       rst_n;
    logic       rst_s_n;

    logic       hsync, vsync, video_on, line_start, frame_start;
    logic [9:0] pixel_x, pixel_y;

    logic       hsync_s, vsync_s, video_on_s, line_start_s, frame_start_s;
    logic [9:0] pixel_x_s, pixel_y_s;

    int checks = 0;
    int errors = 0;

    vga_sync_gen dut (
        .clk_in      (clk),
        .rst_n       (rst_n),
        .hsync       (hsync),
        .vsync       (vsync),
        .video_on    (video_on),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    vga_sync_gen #(
        .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .SYNC_POL (1'b1)
    ) dut_s (
        .clk_in      (clk),
        .rst_n       (rst_s_n),
        .hsync       (hsync_s),
        .vsync       (vsync_s),
        .video_on    (video_on_s),
        .pixel_x     (pixel_x_s),
        .pixel_y     (pixel_y_s),
        .line_start  (line_start_s),
        .frame_start (frame_start_s)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        rst_s_n = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_hsync", int'(hsync), 1);
        chk("rst_vsync", int'(vsync), 1);
        chk("rst_video_on", int'(video_on), 0);
        chk("rst_pixel_x", int'(pixel_x), 0);
        chk("rst_frame_start", int'(frame_start), 0);
        chk("rst_s_hsync", int'(hsync_s), 0);
        rst_n = 1'b1;
        step();
        chk("e1_pixel_x", int'(pixel_x), 0);
        chk("e1_pixel_y", int'(pixel_y), 0);
        chk("e1_video_on", int'(video_on), 1);
        chk("e1_line_start", int'(line_start), 1);
        chk("e1_frame_start", int'(frame_start), 1);
    endtask

    task automatic test_horizontal();
        int von = 0, last_von = -1;
        int hs = 0, first_hs = -1, last_hs = -1;
        int bad = 0;
        for (int i = 0; i < 800; i++) begin
            if (int'(pixel_x) != i || pixel_y != 10'd0) bad++;
            if (line_start !== (i == 0)) bad++;
            if (video_on === 1'b1) begin
                von++;
                last_von = i;
            end
            if (hsync === 1'b0) begin
                hs++;
                if (first_hs < 0) first_hs = i;
                last_hs = i;
            end
            step();
        end
        chk("h_video_cycles", von, 640);
        chk("h_last_video_x", last_von, 639);
        chk("h_sync_cycles", hs, 96);
        chk("h_sync_first_x", first_hs, 656);
        chk("h_sync_last_x", last_hs, 751);
        chk("h_line_bad", bad, 0);
        chk("h_next_x", int'(pixel_x), 0);
        chk("h_next_y", int'(pixel_y), 1);
        chk("h_next_line_start", int'(line_start), 1);
        chk("h_next_frame_start", int'(frame_start), 0);
    endtask

    task automatic test_mid_reset_default();
        repeat (300) step();
        chk("mr_pre_x", int'(pixel_x), 300);
        rst_n = 1'b0;
        #1;
        chk("mr_x", int'(pixel_x), 0);
        chk("mr_y", int'(pixel_y), 0);
        chk("mr_video_on", int'(video_on), 0);
        chk("mr_hsync", int'(hsync), 1);
        rst_n = 1'b1;
        step();
        chk("mr_e1_x", int'(pixel_x), 0);
        chk("mr_e1_y", int'(pixel_y), 0);
        chk("mr_e1_frame_start", int'(frame_start), 1);
    endtask

    task automatic test_small_frame();
        int von = 0, ls = 0, fs = 0, bad = 0, vs_bad = 0, hs = 0;
        int ex, ey;
        logic prev_vs;
        rst_s_n = 1'b0;
        @(negedge clk);
        rst_s_n = 1'b1;
        step();
        prev_vs = vsync_s;
        for (int c = 0; c < 48; c++) begin
            ex = c % 8;
            ey = c / 8;
            if (int'(pixel_x_s) != ex || int'(pixel_y_s) != ey) bad++;
            if (hsync_s !== (ex >= 5 && ex <= 6)) bad++;
            if (vsync_s !== (ey == 4)) bad++;
            if (video_on_s !== (ex < 4 && ey < 3)) bad++;
            if (line_start_s !== (ex == 0)) bad++;
            if (frame_start_s !== (c == 0)) bad++;
            if (vsync_s !== prev_vs && pixel_x_s != 10'd0) vs_bad++;
            prev_vs = vsync_s;
            if (video_on_s) von++;
            if (line_start_s) ls++;
            if (frame_start_s) fs++;
            if (hsync_s) hs++;
            if (c == 24) begin
                chk("s_vbound_y", int'(pixel_y_s), 3);
                chk("s_vbound_video_on", int'(video_on_s), 0);
                chk("s_vbound_line_start", int'(line_start_s), 1);
                chk("s_vbound_frame_start", int'(frame_start_s), 0);
            end
            step();
        end
        chk("s_model_bad", bad, 0);
        chk("s_vsync_edge_bad", vs_bad, 0);
        chk("s_video_cycles", von, 12);
        chk("s_line_starts", ls, 6);
        chk("s_frame_starts", fs, 1);
        chk("s_hsync_cycles", hs, 12);
        chk("s_wrap_x", int'(pixel_x_s), 0);
        chk("s_wrap_y", int'(pixel_y_s), 0);
        chk("s_wrap_line_start", int'(line_start_s), 1);
        chk("s_wrap_frame_start", int'(frame_start_s), 1);
        chk("s_wrap_video_on", int'(video_on_s), 1);
    endtask

    task automatic test_small_mid_reset();
        int n = 0;
        while (pixel_y_s != 10'd2 && n < 100) begin
            step();
            n++;
        end
        chk("smr_reach_y2", int'(pixel_y_s), 2);
        step();
        step();
        chk("smr_pre_x", int'(pixel_x_s), 2);
        rst_s_n = 1'b0;
        #1;
        chk("smr_x", int'(pixel_x_s), 0);
        chk("smr_y", int'(pixel_y_s), 0);
        chk("smr_hsync", int'(hsync_s), 0);
        chk("smr_vsync", int'(vsync_s), 0);
        chk("smr_video_on", int'(video_on_s), 0);
        rst_s_n = 1'b1;
        step();
        chk("smr_e1_x", int'(pixel_x_s), 0);
        chk("smr_e1_y", int'(pixel_y_s), 0);
        chk("smr_e1_frame_start", int'(frame_start_s), 1);
        chk("smr_e1_video_on", int'(video_on_s), 1);
    endtask

    initial begin
        rst_n   = 1'b0;
        rst_s_n = 1'b0;
        test_reset();
        test_horizontal();
        test_mid_reset_default();
        test_small_frame();
        test_small_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
